// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Contents: frame state enum, data-bit count, default baud/FIFO sizing.
package uart_pkg;

    // Frame sequencing states of the transmitter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int unsigned UART_DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en, wr_data    - enqueue strobe and data (dropped while full)
//   rd_en, rd_data    - dequeue strobe; rd_data shows the head entry
//   full, empty, count- registered occupancy status
//   overflow          - sticky, set by a write attempt while full
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;  // extra wrap bit separates full from empty

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q, overflow_q;
    logic             wr_ok_c, rd_ok_c;

    assign wr_ok_c = wr_en && !full_q;
    assign rd_ok_c = rd_en && !empty_q;

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_ok_c) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = CW'(wr_ptr_d - rd_ptr_d);
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_q | (wr_en & full_q);
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed serialiser.
// Frames go out LSB first, back to back with no idle gap while data is queued.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_data, wr_en  - byte enqueue
//   full, empty     - FIFO status
//   count           - bytes queued (not counting the one being shifted)
//   busy            - a frame is in progress
//   overflow        - sticky write-while-full flag
//   uart_tx         - registered serial line, idle high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter  int unsigned FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH,
    localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          overflow,
    output logic          uart_tx
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(UART_DATA_BITS);
    localparam int unsigned DW = UART_DATA_BITS;

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           pop_c;
    logic           baud_wrap_c;
    logic [DW-1:0]  head_c;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_c),
        .rd_data  (head_c),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign baud_wrap_c = (baud_q == BW'(CLKS_PER_BIT - 1));

    // Next-state, datapath and line value; the line lags the state by one edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    idx_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_wrap_c) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_wrap_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DW-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DW - 1)) state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, overflow, uart_tx;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] sb[$];
    int         starts_q[$];
    bit         mon_active = 1'b0;
    int         mon_s = 0;
    logic [7:0] mon_byte = 8'h00;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .overflow (overflow),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes frames at bit centres and scores them against the queue.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (uart_tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_s = 0;
                    mon_byte = 8'h00;
                    starts_q.push_back(cyc);
                end
            end else begin
                mon_s++;
                if (mon_s == 2) begin
                    checks++;
                    if (uart_tx !== 1'b0) begin
                        failures++;
                        $display("FAIL mon_start_bit: got %b expected 0", uart_tx);
                    end
                end else if (mon_s >= 6 && mon_s <= 34 && ((mon_s - 6) % 4) == 0) begin
                    mon_byte = {uart_tx, mon_byte[7:1]};
                end else if (mon_s == 38) begin
                    checks++;
                    if (uart_tx !== 1'b1) begin
                        failures++;
                        $display("FAIL mon_stop_bit: got %b expected 1", uart_tx);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL mon_unexpected_frame: got %02h expected no frame", mon_byte);
                    end else begin
                        exp_b = sb.pop_front();
                        if (mon_byte !== exp_b) begin
                            failures++;
                            $display("FAIL mon_frame_data: got %02h expected %02h", mon_byte, exp_b);
                        end
                    end
                end else if (mon_s == 39) begin
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    // Presents one write for the next rising edge; returns at the following negedge.
    task automatic drive_write(input logic [7:0] d, input bit accepted);
        wr_en = 1'b1;
        wr_data = d;
        if (accepted) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || mon_active || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || mon_active || busy) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes pending after %0d cycles, expected 0", name, sb.size(), n);
        end
    endtask

    task automatic check_gaps(input int n_exp, input string name);
        checks++;
        if (starts_q.size() != n_exp) begin
            failures++;
            $display("FAIL %s_frames: got %0d frames expected %0d", name, starts_q.size(), n_exp);
        end else begin
            for (int i = 1; i < n_exp; i++) begin
                checks++;
                if (starts_q[i] - starts_q[i-1] != FRAME) begin
                    failures++;
                    $display("FAIL %s_spacing: got %0d cycles expected %0d", name,
                             starts_q[i] - starts_q[i-1], FRAME);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({uart_tx, empty, busy, full, overflow, count} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_state: got tx=%b empty=%b busy=%b full=%b ovf=%b count=%0d expected 1 1 0 0 0 0",
                     uart_tx, empty, busy, full, overflow, count);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({uart_tx, empty, busy, count} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
                failures++;
                $display("FAIL idle_hold: cycle %0d got tx=%b empty=%b busy=%b count=%0d expected 1 1 0 0",
                         i, uart_tx, empty, busy, count);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       exp_tx;
        d = 8'hA5;
        drive_write(d, 1'b1);
        checks++;
        if ({count, empty, busy, uart_tx} !== {3'd1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL single_after_write: got count=%0d empty=%b busy=%b tx=%b expected 1 0 0 1",
                     count, empty, busy, uart_tx);
        end
        @(negedge clk);
        checks++;
        if ({count, empty, busy, uart_tx} !== {3'd0, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_after_pop: got count=%0d empty=%b busy=%b tx=%b expected 0 1 1 1",
                     count, empty, busy, uart_tx);
        end
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (j < CPB) exp_tx = 1'b0;
            else if (j < 9 * CPB) exp_tx = d[(j - CPB) / CPB];
            else exp_tx = 1'b1;
            checks++;
            if (uart_tx !== exp_tx) begin
                failures++;
                $display("FAIL single_wave: offset %0d got %b expected %b", j, uart_tx, exp_tx);
            end
            if (j == FRAME - 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL single_busy_last: got %b expected 1", busy);
                end
            end
            if (j == FRAME - 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_busy_fall: got %b expected 0", busy);
                end
            end
        end
        wait_drain(20, "single");
    endtask

    task automatic test_burst_overflow();
        starts_q.delete();
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            sb.push_back(8'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL burst_full: got full=%b count=%0d ovf=%b expected 1 4 0", full, count, overflow);
        end
        drive_write(8'hFF, 1'b0);
        checks++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL overflow_set: got full=%b count=%0d ovf=%b expected 1 4 1", full, count, overflow);
        end
        wait_drain(6 * FRAME, "burst");
        check_gaps(5, "burst");
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_stop_boundary();
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: got %b expected 0", overflow);
        end
        starts_q.delete();
        drive_write(8'h11, 1'b1);
        drive_write(8'h22, 1'b1);
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL boundary_queued: got count=%0d expected 1", count);
        end
        repeat (FRAME - 1) @(negedge clk);
        checks++;
        if ({count, busy} !== {3'd1, 1'b1}) begin
            failures++;
            $display("FAIL boundary_before: got count=%0d busy=%b expected 1 1", count, busy);
        end
        drive_write(8'h55, 1'b1);
        checks++;
        if ({count, busy} !== {3'd1, 1'b1}) begin
            failures++;
            $display("FAIL boundary_pop_write: got count=%0d busy=%b expected 1 1", count, busy);
        end
        wait_drain(4 * FRAME, "boundary");
        check_gaps(3, "boundary");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        starts_q.delete();
        drive_write(8'h3C, 1'b1);
        drive_write(8'hAA, 1'b1);
        drive_write(8'hBB, 1'b1);
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL midrst_queued: got count=%0d expected 2", count);
        end
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({uart_tx, busy, empty, full, count, overflow} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL midrst_state: got tx=%b busy=%b empty=%b full=%b count=%0d ovf=%b expected 1 0 1 0 0 0",
                     uart_tx, busy, empty, full, count, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        starts_q.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({uart_tx, busy, empty} !== {1'b1, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL midrst_quiet: cycle %0d got tx=%b busy=%b empty=%b expected 1 0 1",
                         i, uart_tx, busy, empty);
            end
        end
        checks++;
        if (starts_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_no_frames: got %0d frames expected 0", starts_q.size());
        end
        drive_write(8'h5A, 1'b1);
        wait_drain(2 * FRAME, "midrst_resume");
        check_gaps(1, "midrst_resume");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_stop_boundary();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
